// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 2R/1W register file with per-register busy scoreboard (optional ZERO_REG_EN: hardwired zero register)
module reg_file_sb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  input  logic              rsv_valid_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic              rsv_ready_o,
  input  logic              rd_wren_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [ADDR_W:0]   busy_cnt_o
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef ZERO_REG_EN
  localparam logic ZERO_EN = 1'b1;
`else
  localparam logic ZERO_EN = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   busy_cnt;
  logic [ADDR_W:0]   busy_cnt_nxt;

  logic wr_en;
  logic rsv_acc;
  logic cnt_inc;
  logic cnt_dec;

  // A hardwired-zero register swallows both writes and reservations
  assign wr_en   = rd_wren_i & ~(ZERO_EN & (rd_addr_i == '0));
  assign rsv_acc = rsv_valid_i & rsv_ready_o & ~(ZERO_EN & (rsv_addr_i == '0));

  // A register is reservable when free or being written back this very cycle
  assign rsv_ready_o = rst_ni & (~busy[rsv_addr_i] | (rd_wren_i & (rd_addr_i == rsv_addr_i)));

  // Read port 1: write-first bypass, forced to zero while in reset
  always_comb begin
    rs1_data_o = '0;
    rs1_busy_o = 1'b0;
    if (rst_ni && !(ZERO_EN && rs1_addr_i == '0)) begin
      if (rd_wren_i && rd_addr_i == rs1_addr_i) begin
        rs1_data_o = rd_data_i;
      end else begin
        rs1_data_o = mem[rs1_addr_i];
        rs1_busy_o = busy[rs1_addr_i];
      end
    end
  end

  // Read port 2: identical to port 1
  always_comb begin
    rs2_data_o = '0;
    rs2_busy_o = 1'b0;
    if (rst_ni && !(ZERO_EN && rs2_addr_i == '0)) begin
      if (rd_wren_i && rd_addr_i == rs2_addr_i) begin
        rs2_data_o = rd_data_i;
      end else begin
        rs2_data_o = mem[rs2_addr_i];
        rs2_busy_o = busy[rs2_addr_i];
      end
    end
  end

  // Next busy vector: writeback clears first, so a colliding reservation wins
  always_comb begin
    busy_nxt = busy;
    if (wr_en) begin
      busy_nxt[rd_addr_i] = 1'b0;
    end
    if (rsv_acc) begin
      busy_nxt[rsv_addr_i] = 1'b1;
    end
  end

  // Counter tracks real 0->1 and 1->0 transitions so it always equals the popcount
  always_comb begin
    cnt_inc = rsv_acc & ~busy[rsv_addr_i];
    cnt_dec = wr_en & busy[rd_addr_i] & ~(rsv_acc & (rsv_addr_i == rd_addr_i));
    busy_cnt_nxt = busy_cnt;
    if (cnt_inc && !cnt_dec) begin
      busy_cnt_nxt = busy_cnt + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      busy_cnt_nxt = busy_cnt - 1'b1;
    end
  end

  // Storage, scoreboard and counter state; reset discards all reservations
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_en) begin
        mem[rd_addr_i] <= rd_data_i;
      end
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt_nxt;
    end
  end

  assign busy_cnt_o = busy_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb (honours ZERO_REG_EN)
module tb_reg_file_sb;

  logic       clk;
  logic       rst_n;
  logic [2:0] rs1_addr;
  logic [2:0] rs2_addr;
  logic [7:0] rs1_data;
  logic [7:0] rs2_data;
  logic       rs1_busy;
  logic       rs2_busy;
  logic       rsv_valid;
  logic [2:0] rsv_addr;
  logic       rsv_ready;
  logic       rd_wren;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] busy_cnt;

  int errors = 0;
  int checks = 0;

`ifdef ZERO_REG_EN
  localparam logic [3:0] FILL_CNT = 4'd7;
  localparam logic       BUSY0    = 1'b0;
`else
  localparam logic [3:0] FILL_CNT = 4'd8;
  localparam logic       BUSY0    = 1'b1;
`endif

  reg_file_sb #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .rsv_valid_i(rsv_valid),
    .rsv_addr_i (rsv_addr),
    .rsv_ready_o(rsv_ready),
    .rd_wren_i  (rd_wren),
    .rd_addr_i  (rd_addr),
    .rd_data_i  (rd_data),
    .busy_cnt_o (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_wren = 1'b1; rd_addr = 3'd1; rd_data = 8'h09;
    rs1_addr = 3'd1; rsv_addr = 3'd1;
    #1;
    checks++; if (rs1_data !== 8'h00) begin errors++; $display("FAIL rst_forced_data: got %0h want 0", rs1_data); end
    checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL rst_forced_ready: got %0b want 0", rsv_ready); end
    tick();
    rd_wren = 1'b0; rst_n = 1'b1;
    #1;
    for (int a = 0; a < 8; a++) begin
      rs1_addr = 3'(a); rs2_addr = 3'(7 - a);
      #1;
      checks++; if (rs1_data !== 8'h00 || rs1_busy !== 1'b0) begin errors++; $display("FAIL rst_rs1 a=%0d: got %0h/%0b want 0/0", a, rs1_data, rs1_busy); end
      checks++; if (rs2_data !== 8'h00 || rs2_busy !== 1'b0) begin errors++; $display("FAIL rst_rs2 a=%0d: got %0h/%0b want 0/0", a, rs2_data, rs2_busy); end
    end
    checks++; if (busy_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", busy_cnt); end
    checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %0b want 1", rsv_ready); end
  endtask

  task automatic test_write_read();
    rd_wren = 1'b1; rd_addr = 3'd2; rd_data = 8'h04;
    tick();
    rd_wren = 1'b0; rs1_addr = 3'd2; rs2_addr = 3'd2;
    #1;
    checks++; if (rs1_data !== 8'h04 || rs2_data !== 8'h04) begin errors++; $display("FAIL wr_rd: got %0h,%0h want 4,4", rs1_data, rs2_data); end
    rd_wren = 1'b1; rd_addr = 3'd5; rd_data = 8'h05; rs1_addr = 3'd5; rs2_addr = 3'd2;
    #1;
    checks++; if (rs1_data !== 8'h05 || rs1_busy !== 1'b0) begin errors++; $display("FAIL bypass: got %0h/%0b want 5/0", rs1_data, rs1_busy); end
    checks++; if (rs2_data !== 8'h04) begin errors++; $display("FAIL bypass_other: got %0h want 4", rs2_data); end
    tick();
    rd_addr = 3'd6; rd_data = 8'h66;
    tick();
    rd_wren = 1'b0; rs1_addr = 3'd6;
    #1;
    checks++; if (rs1_data !== 8'h66 || rs1_busy !== 1'b0 || busy_cnt !== 4'd0) begin errors++; $display("FAIL wr_not_busy: got %0h/%0b/%0d want 66/0/0", rs1_data, rs1_busy, busy_cnt); end
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1'b1; rsv_addr = 3'd3;
    #1;
    checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL sb_ready1: got %0b want 1", rsv_ready); end
    tick();
    rsv_valid = 1'b0; rs1_addr = 3'd3;
    #1;
    checks++; if (rs1_busy !== 1'b1 || busy_cnt !== 4'd1) begin errors++; $display("FAIL sb_busy: got %0b/%0d want 1/1", rs1_busy, busy_cnt); end
    rsv_valid = 1'b1;
    #1;
    checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL sb_waw: got %0b want 0", rsv_ready); end
    tick();
    rsv_valid = 1'b0;
    #1;
    checks++; if (busy_cnt !== 4'd1 || rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_waw_hold: got %0d/%0b want 1/1", busy_cnt, rs1_busy); end
    rd_wren = 1'b1; rd_addr = 3'd3; rd_data = 8'hFF;
    #1;
    checks++; if (rs1_busy !== 1'b0 || rs1_data !== 8'hFF) begin errors++; $display("FAIL sb_bypass_busy: got %0b/%0h want 0/ff", rs1_busy, rs1_data); end
    tick();
    rd_wren = 1'b0;
    #1;
    checks++; if (rs1_busy !== 1'b0 || busy_cnt !== 4'd0 || rs1_data !== 8'hFF) begin errors++; $display("FAIL sb_wb: got %0b/%0d/%0h want 0/0/ff", rs1_busy, busy_cnt, rs1_data); end
  endtask

  task automatic test_collision();
    rsv_valid = 1'b1; rsv_addr = 3'd3;
    tick();
    rd_wren = 1'b1; rd_addr = 3'd3; rd_data = 8'h11;
    #1;
    checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL col_ready: got %0b want 1", rsv_ready); end
    tick();
    rd_wren = 1'b0; rsv_valid = 1'b0; rs1_addr = 3'd3;
    #1;
    checks++; if (rs1_data !== 8'h11 || rs1_busy !== 1'b1 || busy_cnt !== 4'd1) begin errors++; $display("FAIL col_state: got %0h/%0b/%0d want 11/1/1", rs1_data, rs1_busy, busy_cnt); end
    rd_wren = 1'b1; rd_data = 8'hFF;
    tick();
    rd_wren = 1'b0;
    #1;
    checks++; if (busy_cnt !== 4'd0 || rs1_data !== 8'hFF) begin errors++; $display("FAIL col_free: got %0d/%0h want 0/ff", busy_cnt, rs1_data); end
  endtask

  task automatic test_fill_reset();
    logic exp_b;
    rsv_valid = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rsv_addr = 3'(a);
      tick();
    end
    rsv_valid = 1'b0;
    #1;
    checks++; if (busy_cnt !== FILL_CNT) begin errors++; $display("FAIL fill_cnt: got %0d want %0d", busy_cnt, FILL_CNT); end
    for (int a = 0; a < 8; a++) begin
      rs1_addr = 3'(a);
      exp_b = (a == 0) ? BUSY0 : 1'b1;
      #1;
      checks++; if (rs1_busy !== exp_b) begin errors++; $display("FAIL fill_busy a=%0d: got %0b want %0b", a, rs1_busy, exp_b); end
    end
    rsv_addr = 3'd4;
    #1;
    checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %0b want 0", rsv_ready); end
    rd_wren = 1'b1; rd_addr = 3'd7; rd_data = 8'h77;
    tick();
    rd_wren = 1'b0;
    #1;
    checks++; if (busy_cnt !== FILL_CNT - 4'd1) begin errors++; $display("FAIL dec_cnt: got %0d want %0d", busy_cnt, FILL_CNT - 4'd1); end
    rsv_valid = 1'b1; rsv_addr = 3'd7; rst_n = 1'b0;
    #1;
    checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %0b want 0", rsv_ready); end
    tick();
    rst_n = 1'b1; rsv_valid = 1'b0;
    #1;
    checks++; if (busy_cnt !== 4'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", busy_cnt); end
    for (int a = 0; a < 8; a++) begin
      rs1_addr = 3'(a);
      #1;
      checks++; if (rs1_busy !== 1'b0 || rs1_data !== 8'h00) begin errors++; $display("FAIL mid_rst a=%0d: got %0b/%0h want 0/0", a, rs1_busy, rs1_data); end
    end
    rd_wren = 1'b1; rd_addr = 3'd4; rd_data = 8'h33;
    tick();
    rd_wren = 1'b0; rs1_addr = 3'd4;
    #1;
    checks++; if (rs1_data !== 8'h33 || rs1_busy !== 1'b0 || busy_cnt !== 4'd0) begin errors++; $display("FAIL late_wb: got %0h/%0b/%0d want 33/0/0", rs1_data, rs1_busy, busy_cnt); end
  endtask

  task automatic test_zero_reg();
`ifdef ZERO_REG_EN
    rd_wren = 1'b1; rd_addr = 3'd0; rd_data = 8'hAA; rs1_addr = 3'd0;
    #1;
    checks++; if (rs1_data !== 8'h00) begin errors++; $display("FAIL z_bypass: got %0h want 0", rs1_data); end
    tick();
    rd_wren = 1'b0;
    #1;
    checks++; if (rs1_data !== 8'h00) begin errors++; $display("FAIL z_read: got %0h want 0", rs1_data); end
    rsv_valid = 1'b1; rsv_addr = 3'd0;
    #1;
    checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL z_ready: got %0b want 1", rsv_ready); end
    tick();
    rsv_valid = 1'b0;
    #1;
    checks++; if (rs1_busy !== 1'b0 || busy_cnt !== 4'd0) begin errors++; $display("FAIL z_rsv: got %0b/%0d want 0/0", rs1_busy, busy_cnt); end
`else
    rd_wren = 1'b1; rd_addr = 3'd0; rd_data = 8'hAA;
    tick();
    rd_wren = 1'b0; rs1_addr = 3'd0;
    #1;
    checks++; if (rs1_data !== 8'hAA) begin errors++; $display("FAIL r0_read: got %0h want aa", rs1_data); end
    rsv_valid = 1'b1; rsv_addr = 3'd0;
    tick();
    rsv_valid = 1'b0;
    #1;
    checks++; if (rs1_busy !== 1'b1 || busy_cnt !== 4'd1) begin errors++; $display("FAIL r0_rsv: got %0b/%0d want 1/1", rs1_busy, busy_cnt); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; rs1_addr = '0; rs2_addr = '0; rsv_valid = 1'b0; rsv_addr = '0;
    rd_wren = 1'b0; rd_addr = '0; rd_data = '0;
    tick();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_collision();
    test_fill_reset();
    test_zero_reg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
